border_pad: RTL and testbench

BORDER_PAD -- requirements
Module: border_pad

---
 rtl/border_pad.sv | 158 +++++++++++++++
 tb/tb_border_pad.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/border_pad.sv
// Border padder: surrounds every incoming frame with PAD rows and columns of PAD_VALUE
// so a WINDOW_SIZE x WINDOW_SIZE filter downstream produces a full-size output frame.
module border_pad #(
    parameter int DATA_WIDTH   = 8,
    parameter int WINDOW_SIZE  = 3,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int PAD_VALUE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  err_pulse
);
    localparam int PAD    = (WINDOW_SIZE - 1) / 2;
    localparam int OUT_W  = FRAME_WIDTH + 2 * PAD;
    localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int PROW_W = $clog2(PAD + 1);

    localparam logic [COL_W-1:0]      COL_LAST    = COL_W'(OUT_W - 1);
    localparam logic [COL_W-1:0]      COL_LEFT    = COL_W'(PAD - 1);
    localparam logic [COL_W-1:0]      COL_FIRST_A = COL_W'(PAD);
    localparam logic [COL_W-1:0]      COL_LAST_A  = COL_W'(PAD + FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST    = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [PROW_W-1:0]     PROW_LAST   = PROW_W'(PAD - 1);
    localparam logic [DATA_WIDTH-1:0] PAD_PIX     = DATA_WIDTH'(PAD_VALUE);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_LEFT, S_ACTIVE, S_RIGHT, S_BOTTOM
    } state_t;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [PROW_W-1:0]       prow_q, prow_d;
    logic                    m_valid_q, m_last_q, m_user_q;
    logic [DATA_WIDTH-1:0]   m_data_q;

    logic                    adv;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    tready_d;
    logic                    err_d;

    assign adv = !m_valid_q || m_axis_tready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        prow_d    = prow_q;
        load      = 1'b0;
        load_data = PAD_PIX;
        tready_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stray beats are swallowed; the frame-start beat is left for ACTIVE.
                tready_d = !s_axis_tuser;
                if (s_axis_tvalid && s_axis_tuser) state_d = S_TOP;
            end
            S_TOP, S_BOTTOM: begin
                if (adv) begin
                    load = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (prow_q == PROW_LAST) begin
                            prow_d  = '0;
                            state_d = (state_q == S_TOP) ? S_LEFT : S_IDLE;
                        end else begin
                            prow_d = prow_q + PROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_LEFT: begin
                if (adv) begin
                    load  = 1'b1;
                    col_d = col_q + COL_W'(1);
                    if (col_q == COL_LEFT) state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                tready_d = adv;
                if (adv && s_axis_tvalid) begin
                    load      = 1'b1;
                    load_data = s_axis_tdata;
                    err_d     = (s_axis_tlast != (col_q == COL_LAST_A)) ||
                                (s_axis_tuser && ((col_q != COL_FIRST_A) || (row_q != '0)));
                    col_d     = col_q + COL_W'(1);
                    if (col_q == COL_LAST_A) state_d = S_RIGHT;
                end
            end
            S_RIGHT: begin
                if (adv) begin
                    load = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_BOTTOM;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_LEFT;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            prow_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            prow_q  <= prow_d;
            if (adv) begin
                m_valid_q <= load;
                m_data_q  <= load_data;
                m_last_q  <= load && (col_q == COL_LAST);
                m_user_q  <= load && (state_q == S_TOP) && (prow_q == '0) && (col_q == '0);
            end
        end
    end

    assign s_axis_tready = tready_d && !rst;
    assign err_pulse     = err_d;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_border_pad.sv
// Bench for border_pad on a 4x3 frame with a 3x3 window: expected padded beats go into a
// queue at stimulus time and a negedge monitor pops and compares each accepted output beat.
module tb_border_pad;
    localparam int DW = 8;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int PV = 0;
    localparam int OW = 6;
    localparam int OH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;
    logic          err_pulse;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur, held, e;
    int    checks = 0, errors = 0;
    int    beats_seen = 0, tuser_seen = 0, err_seen = 0, s_hs = 0;
    int    rst_wait;
    logic  rand_ready = 1'b0, abort = 1'b0, stall_pend = 1'b0;

    assign cur = {m_tdata, m_tlast, m_tuser};

    border_pad #(
        .DATA_WIDTH(DW), .WINDOW_SIZE(3), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PAD_VALUE(PV)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability and err_pulse qualification.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    checks++;
                    if (!m_tvalid || cur != held) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b data=%0d, required valid=1 data=%0d",
                                 m_tvalid, m_tdata, held.d);
                    end
                end
                if (s_tvalid && s_tready) s_hs++;
                if (err_pulse) begin
                    err_seen++;
                    checks++;
                    if (!(s_tvalid && s_tready)) begin
                        errors++;
                        $display("FAIL err_without_handshake: got err_pulse=1, required 0");
                    end
                end
                if (m_tvalid && m_tready) begin
                    beats_seen++;
                    if (m_tuser) tuser_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got data=%0d last=%0b user=%0b, required none",
                                 m_tdata, m_tlast, m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        if (e != cur) begin
                            errors++;
                            $display("FAIL beat %0d: got data=%0d last=%0b user=%0b, required data=%0d last=%0b user=%0b",
                                     beats_seen - 1, m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
                        end else begin
                            $display("beat %0d: data=%0d last=%0b user=%0b",
                                     beats_seen - 1, m_tdata, m_tlast, m_tuser);
                        end
                    end
                end
                stall_pend = m_tvalid && !m_tready;
                held       = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clr();
        beats_seen = 0;
        tuser_seen = 0;
        err_seen   = 0;
        s_hs       = 0;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                b.d = (r >= 1 && r <= FH && c >= 1 && c <= FW) ? DW'((r - 1) * FW + c) : DW'(PV);
                b.l = (c == OW - 1);
                b.u = (r == 0 && c == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic u);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (abort || s_tready) break;
            n++;
            if (n > 500) begin
                chk("input_handshake_timeout", n, 0);
                break;
            end
        end
        if (!abort) begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // Pixels 1..FW*FH; err_idx >= 0 adds a stray tlast on that pixel index.
    task automatic send_frame(input int err_idx);
        for (int i = 0; i < FW * FH; i++) begin
            if (abort) return;
            send_beat(DW'(i + 1), (i % FW == FW - 1) || (i == err_idx), i == 0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with a pending non-tuser beat to show tready is held low.
        s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", int'(m_tvalid), 0);
        chk("rst_m_tdata", int'(m_tdata), 0);
        chk("rst_m_tlast", int'(m_tlast), 0);
        chk("rst_m_tuser", int'(m_tuser), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_s_tready", int'(s_tready), 0);
        s_tvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_s_tready", int'(s_tready), 1);
        @(posedge clk);
        #1;

        // Single frame, ready held high.
        clr();
        push_frame();
        send_frame(-1);
        wait_drain();
        chk("f1_beats", beats_seen, 30);
        chk("f1_tuser", tuser_seen, 1);
        chk("f1_err", err_seen, 0);
        chk("f1_in_hs", s_hs, 12);

        // Random back-pressure.
        clr();
        rand_ready = 1'b1;
        push_frame();
        send_frame(-1);
        wait_drain();
        rand_ready = 1'b0;
        chk("bp_beats", beats_seen, 30);
        chk("bp_in_hs", s_hs, 12);

        // Stray beats before the frame are dropped.
        clr();
        push_frame();
        for (int i = 0; i < 3; i++) send_beat(DW'(8'hA0 + i), 1'b0, 1'b0);
        chk("junk_in_hs", s_hs, 3);
        send_frame(-1);
        wait_drain();
        chk("junk_beats", beats_seen, 30);
        chk("junk_total_hs", s_hs, 15);

        // Early tlast on input col 2 of row 0.
        clr();
        push_frame();
        send_frame(2);
        wait_drain();
        chk("err_count", err_seen, 1);
        chk("err_beats", beats_seen, 30);

        // Reset mid-frame, then a clean frame.
        clr();
        push_frame();
        fork
            send_frame(-1);
            begin
                rst_wait = 0;
                while (beats_seen < 10 && rst_wait < 1000) begin
                    @(posedge clk);
                    rst_wait++;
                end
                chk("rst_trigger_reached", int'(beats_seen >= 10), 1);
                #3;
                rst = 1'b1;
                #1;
                chk("midrst_m_tvalid", int'(m_tvalid), 0);
                chk("midrst_s_tready", int'(s_tready), 0);
                abort = 1'b1;
                exp_q.delete();
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        @(posedge clk);
        #1;
        clr();
        push_frame();
        send_frame(-1);
        wait_drain();
        chk("post_rst_beats", beats_seen, 30);
        chk("post_rst_tuser", tuser_seen, 1);

        // Two back-to-back frames.
        clr();
        push_frame();
        push_frame();
        send_frame(-1);
        send_frame(-1);
        wait_drain();
        chk("b2b_beats", beats_seen, 60);
        chk("b2b_tuser", tuser_seen, 2);
        chk("b2b_err", err_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
